bg_scroll_ctrl: RTL
===================

// Module: bg_scroll_ctrl
// PURPOSE
//  Per-frame camera/scroll controller and pixel address sequencer for the scrolling background.
//  Updates horizontal scroll (scroll_x) once per frame during vsync: player follows a dead zone, speed capped, scroll clamped to image.
//  Generates the registered background ROM/SRAM address per pixel from DrawX/DrawY.
//  Row base is accumulated (no multiplier). Sits between VGA controller/player logic and BG memory.
// PARAMETERS
//  BG_WIDTH   3182  background image width, pixels
//  SCREEN_W   640   visible width
//  SCREEN_H   480   visible height
//  MAX_SCROLL 2542  max scroll_x (BG_WIDTH-SCREEN_W)
//  DEAD_LO    200   screen-relative left dead-zone edge
//  DEAD_HI    400   screen-relative right dead-zone edge
//  MAX_STEP   8     max scroll change per frame, pixels
//  ADDR_W     23    address width
// PORTS
//  Clk          in   1       system clock
//  Reset        in   1       synchronous, active-high
//  VS           in   1       VGA vsync, active-low
//  player_x     in   16      player world X (unsigned)
//  DrawX        in   10      current pixel column
//  DrawY        in   10      current pixel row
//  scroll_x     out  16      committed scroll offset
//  bg_addr      out  ADDR_W  background address, registered
//  bg_addr_vld  out  1       bg_addr valid (visible and row-synced)
//  frame_tick   out  1       1-cycle pulse when scroll_x commits
// BEHAVIOUR
//  Reset: scroll_x=0, bg_addr=0, bg_addr_vld=0, frame_tick=0, FSM=RUN, vs_q=1, row_base=0, y_q=0, synced=0.
//  Reset mid-update abandons the update; scroll_x returns to 0.
//  Frame event: falling edge of VS (vs_q=1, VS=0), registered edge detect.
//  FSM:
//   RUN: frame event -> CALC.
//   CALC: sample player_x; rel = player_x - scroll_x (17b signed) -> STEP.
//   STEP: rel>DEAD_HI: nxt = scroll_x + min(rel-DEAD_HI, MAX_STEP);
//         rel<DEAD_LO: nxt = scroll_x - min(DEAD_LO-rel, MAX_STEP);
//         else nxt = scroll_x.
//         Computed signed 18b -> CLAMP.
//   CLAMP: scroll_x = nxt<0 ? 0 : nxt>MAX_SCROLL ? MAX_SCROLL : nxt; frame_tick=1 -> RUN.
//  frame_tick: asserted 3 cycles after the VS edge cycle.
//  Frame events outside RUN are ignored.
//  scroll_x changes only in CLAMP, i.e. during vsync, so never mid-frame.
//  Row tracking (y_q = previous DrawY, row_base = y_q*BG_WIDTH):
//   DrawY==y_q: row unchanged.
//   DrawY==0:   row_base'=0, synced=1.
//   DrawY==y_q+1: row_base'=row_base+BG_WIDTH.
//   any other change: synced=0 until DrawY==0 is seen.
//  Address, latency 1:
//   bg_addr(t+1) = rowY(t) + DrawX(t) + scroll_x(t), where rowY = row_base' for the current DrawY.
//   Zero-extended to ADDR_W; no overflow at max values (479*3182+639+2542 < 2^23).
//  bg_addr_vld(t+1) = synced' && DrawX(t)<SCREEN_W && DrawY(t)<SCREEN_H.
//   bg_addr still updates when not valid.
// TESTING
//  1 Reset; VS falls, player_x=300 -> scroll_x stays 0; frame_tick pulses exactly once, 3 cycles after the edge cycle.
//  2 player_x=500, 13 frames -> scroll_x 8,16,...,96, then 100 (step 4); stays 100 on frame 14.
//  3 scroll_x=2540, player_x=3100 -> next frame scroll_x=2542 (clamped); further frames hold at 2542.
//  4 scroll_x=4, player_x=0 -> nxt=-4 -> scroll_x=0; player_x=0 next frame -> stays 0.
//  5 scroll_x=100, DrawY 0,1,2 in order, DrawX=5 on row 2 -> next cycle bg_addr=6469, vld=1;
//    DrawX=640 -> vld=0.
//  6 DrawY jumps 5->9 -> vld=0 while DrawY>0; DrawY=0, DrawX=3, scroll_x=100 -> bg_addr=103, vld=1.
//    Also: Reset asserted in STEP -> scroll_x=0, no frame_tick.

Source files
------------

// File: rtl/bg_scroll_if.sv
// Bundle between the VGA/player side (master) and the scroll controller (slave).
interface bg_scroll_if #(
  parameter int ADDR_W = 23
);
  logic              VS;
  logic [15:0]       player_x;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [15:0]       scroll_x;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_addr_vld;
  logic              frame_tick;

  modport master (
    output VS, player_x, DrawX, DrawY,
    input  scroll_x, bg_addr, bg_addr_vld, frame_tick
  );

  modport slave (
    input  VS, player_x, DrawX, DrawY,
    output scroll_x, bg_addr, bg_addr_vld, frame_tick
  );
endinterface

// File: rtl/bg_scroll_ctrl.sv
// Per-frame camera scroll update (dead zone, capped step, clamp) committed during vsync,
// plus a registered background address sequencer with an accumulated row base.
module bg_scroll_ctrl #(
  parameter int BG_WIDTH   = 3182,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int MAX_SCROLL = 2542,
  parameter int DEAD_LO    = 200,
  parameter int DEAD_HI    = 400,
  parameter int MAX_STEP   = 8,
  parameter int ADDR_W     = 23
) (
  input  logic         Clk,
  input  logic         Reset,
  bg_scroll_if.slave   bus
);
  localparam logic signed [17:0] DLO_S  = 18'(DEAD_LO);
  localparam logic signed [17:0] DHI_S  = 18'(DEAD_HI);
  localparam logic signed [17:0] STEP_S = 18'(MAX_STEP);
  localparam logic signed [17:0] MAX_S  = 18'(MAX_SCROLL);
  localparam logic [9:0]         SW     = 10'(SCREEN_W);
  localparam logic [9:0]         SH     = 10'(SCREEN_H);
  localparam logic [ADDR_W-1:0]  BGW    = ADDR_W'(BG_WIDTH);

  typedef enum logic [1:0] {RUN, CALC, STEP, CLAMP} state_t;

  state_t             state_q;
  logic               vs_q;
  logic [15:0]        scroll_x_q;
  logic signed [16:0] rel_q;
  logic signed [17:0] nxt_q;
  logic               frame_tick_q;

  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic [9:0]         y_q;
  logic               synced_q, synced_d;
  logic [ADDR_W-1:0]  bg_addr_q, bg_addr_d;
  logic               bg_addr_vld_q, bg_addr_vld_d;

  logic               frame_evt;
  logic signed [17:0] rel_x, scroll_s, diff_hi, diff_lo, nxt_d;

  assign frame_evt = vs_q & ~bus.VS;

  // Dead-zone step, evaluated from the registered rel in STEP.
  always_comb begin
    rel_x    = {rel_q[16], rel_q};
    scroll_s = $signed({2'b00, scroll_x_q});
    diff_hi  = rel_x - DHI_S;
    diff_lo  = DLO_S - rel_x;
    nxt_d    = scroll_s;
    if (rel_x > DHI_S)
      nxt_d = scroll_s + ((diff_hi > STEP_S) ? STEP_S : diff_hi);
    else if (rel_x < DLO_S)
      nxt_d = scroll_s - ((diff_lo > STEP_S) ? STEP_S : diff_lo);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= RUN;
      vs_q         <= 1'b1;
      scroll_x_q   <= '0;
      rel_q        <= '0;
      nxt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_q         <= bus.VS;
      frame_tick_q <= 1'b0;
      case (state_q)
        RUN:   if (frame_evt) state_q <= CALC;
        CALC: begin
          rel_q   <= $signed({1'b0, bus.player_x}) - $signed({1'b0, scroll_x_q});
          state_q <= STEP;
        end
        STEP: begin
          nxt_q   <= nxt_d;
          state_q <= CLAMP;
        end
        CLAMP: begin
          if (nxt_q < 18'sd0)     scroll_x_q <= '0;
          else if (nxt_q > MAX_S) scroll_x_q <= MAX_S[15:0];
          else                    scroll_x_q <= nxt_q[15:0];
          frame_tick_q <= 1'b1;
          state_q      <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Row 0 takes priority so a fresh reset (y_q=0) still syncs on the first row-0 pixel.
  always_comb begin
    row_base_d = row_base_q;
    synced_d   = synced_q;
    if (bus.DrawY == 10'd0) begin
      row_base_d = '0;
      synced_d   = 1'b1;
    end else if (bus.DrawY == y_q) begin
      row_base_d = row_base_q;
    end else if ({1'b0, bus.DrawY} == ({1'b0, y_q} + 11'd1)) begin
      row_base_d = row_base_q + BGW;
    end else begin
      synced_d   = 1'b0;
    end
    bg_addr_d     = row_base_d + ADDR_W'(bus.DrawX) + ADDR_W'(scroll_x_q);
    bg_addr_vld_d = synced_d && (bus.DrawX < SW) && (bus.DrawY < SH);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_base_q    <= '0;
      y_q           <= '0;
      synced_q      <= 1'b0;
      bg_addr_q     <= '0;
      bg_addr_vld_q <= 1'b0;
    end else begin
      row_base_q    <= row_base_d;
      y_q           <= bus.DrawY;
      synced_q      <= synced_d;
      bg_addr_q     <= bg_addr_d;
      bg_addr_vld_q <= bg_addr_vld_d;
    end
  end

  assign bus.scroll_x    = scroll_x_q;
  assign bus.bg_addr     = bg_addr_q;
  assign bus.bg_addr_vld = bg_addr_vld_q;
  assign bus.frame_tick  = frame_tick_q;
endmodule
